// File: rtl/counter_ctrl_pkg.sv
// Shared types and default constants for the mod-16 counter input-conditioning stage.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CLR_CYCLES_DEF      = 2;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a stability counter; upd strobes on the
// cycle a new level is accepted into stable.
module debouncer
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic stable,
  output logic upd
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;

  assign upd = (sync2_reg != stable) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      stable    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= din_raw;
      sync2_reg <= sync1_reg;
      // Any return to the accepted level throws away the partial count.
      if (sync2_reg == stable) begin
        cnt_reg <= '0;
      end else if (upd) begin
        stable  <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod16_counter_ctrl.sv
// Debounces the clear button and direction switch and sequences the counter's
// synchronous reset so every clear or direction change reloads it cleanly.
module mod16_counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CLR_CYCLES      = CLR_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_clear,
  input  logic       sw_down,
  output logic       count_reset,
  output logic       count_down,
  output logic [1:0] state_dbg
);

  localparam int BTN = 0;
  localparam int DIR = 1;
  localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CCW-1:0] CLR_LAST = CCW'(CLR_CYCLES - 1);

  logic [1:0] raw_in;
  logic [1:0] deb_stable;
  logic [1:0] deb_upd;

  assign raw_in = {sw_down, btn_clear};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .din_raw(raw_in[gi]),
        .stable (deb_stable[gi]),
        .upd    (deb_upd[gi])
      );
    end
  endgenerate

  logic press;
  logic release_evt;
  logic dir_chg;
  logic clr_level_next;

  assign press          = deb_upd[BTN] & ~deb_stable[BTN];
  assign release_evt    = deb_upd[BTN] &  deb_stable[BTN];
  assign dir_chg        = deb_upd[DIR];
  // Level the clear debouncer will hold after this edge, so a release
  // accepted on the CLEAR exit edge does not strand the FSM in HOLD.
  assign clr_level_next = deb_stable[BTN] ^ deb_upd[BTN];

  ctrl_state_t    state_reg;
  ctrl_state_t    state_next;
  logic [CCW-1:0] clr_cnt_reg;
  logic [CCW-1:0] clr_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (press || dir_chg) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        if (dir_chg) begin
          clr_cnt_next = '0;
        end else if (clr_cnt_reg == CLR_LAST) begin
          state_next   = clr_level_next ? HOLD : IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (release_evt) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_cnt_next = '0;
      end
    endcase
  end

  assign count_reset = (state_reg != IDLE);
  assign count_down  = deb_stable[DIR];
  assign state_dbg   = state_reg;

endmodule

// File: tb/tb_mod16_counter_ctrl.sv
// Directed bench for mod16_counter_ctrl: window-based behavioural model checked
// every cycle, plus hand-computed latency and counter-reload checkpoints.
module tb_mod16_counter_ctrl;

  localparam int DEB = 4;
  localparam int CLR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_down = 1'b0;
  logic       count_reset;
  logic       count_down;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mod16_counter_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CLR_CYCLES     (CLR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_clear  (btn_clear),
    .sw_down    (sw_down),
    .count_reset(count_reset),
    .count_down (count_down),
    .state_dbg  (state_dbg)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a raw level is accepted once the DEB samples taken 2..DEB+1 edges
  // ago all disagree with the accepted level.
  bit c_q[$];
  bit d_q[$];
  bit m_c, m_d, m_hold;
  int m_left;
  bit c_acc, d_acc, m_press, m_rel;

  function automatic bit window_flip(input bit q[$], input bit cur);
    for (int k = 0; k < DEB; k++)
      if (q[q.size() - 3 - k] == cur) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_init();
    c_q.delete();
    d_q.delete();
    for (int i = 0; i < 8; i++) begin
      c_q.push_back(1'b0);
      d_q.push_back(1'b0);
    end
    m_c = 1'b0;
    m_d = 1'b0;
    m_left = CLR;
    m_hold = 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_init();
    end else begin
      c_q.push_back(btn_clear);
      d_q.push_back(sw_down);
      if (c_q.size() > 32) void'(c_q.pop_front());
      if (d_q.size() > 32) void'(d_q.pop_front());
      c_acc   = window_flip(c_q, m_c);
      d_acc   = window_flip(d_q, m_d);
      m_press = c_acc && !m_c;
      m_rel   = c_acc && m_c;
      if (c_acc) m_c = !m_c;
      if (d_acc) m_d = !m_d;
      if (m_left > 0) begin
        if (d_acc) m_left = CLR;
        else begin
          m_left--;
          if (m_left == 0) m_hold = m_c;
        end
      end else if (m_hold) begin
        if (m_rel) m_hold = 1'b0;
      end else if (m_press || d_acc) begin
        m_left = CLR;
      end
    end
  end

  // Downstream mod-16 up/down counter fed by the DUT outputs.
  logic [3:0] ctr;
  always @(posedge clk) begin
    if (count_reset) ctr <= count_down ? 4'd15 : 4'd0;
    else if (count_down) ctr <= ctr - 4'd1;
    else ctr <= ctr + 4'd1;
  end

  int exp_state;
  always @(negedge clk) begin
    if (check_en) begin
      exp_state = (m_left > 0) ? 1 : (m_hold ? 2 : 0);
      chk("cyc_count_reset", 4'(count_reset), 4'(exp_state != 0));
      chk("cyc_count_down", 4'(count_down), 4'(m_d));
      chk("cyc_state_dbg", 4'(state_dbg), 4'(exp_state));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Power-up
    tick(1);
    check_en = 1'b1;
    tick(2);
    chk("rst_count_reset", 4'(count_reset), 4'd1);
    chk("rst_state", 4'(state_dbg), 4'd1);
    chk("rst_count_down", 4'(count_down), 4'd0);
    reset = 1'b1;
    tick(1);
    chk("pu_edge1_state", 4'(state_dbg), 4'd1);
    tick(1);
    chk("pu_edge2_state", 4'(state_dbg), 4'd0);
    chk("pu_edge2_count_reset", 4'(count_reset), 4'd0);
    tick(3);

    // Clean press, held 20 cycles
    btn_clear = 1'b1;
    tick(5);
    chk("press_e5_count_reset", 4'(count_reset), 4'd0);
    tick(1);
    chk("press_e6_count_reset", 4'(count_reset), 4'd1);
    chk("press_e6_state", 4'(state_dbg), 4'd1);
    tick(2);
    chk("press_hold_state", 4'(state_dbg), 4'd2);
    tick(12);
    btn_clear = 1'b0;
    tick(5);
    chk("rel_e5_count_reset", 4'(count_reset), 4'd1);
    tick(1);
    chk("rel_e6_count_reset", 4'(count_reset), 4'd0);
    chk("rel_e6_state", 4'(state_dbg), 4'd0);
    tick(3);

    // Bounce 1,0,1,0 then steady 1
    btn_clear = 1'b1; tick(1);
    btn_clear = 1'b0; tick(1);
    btn_clear = 1'b1; tick(1);
    btn_clear = 1'b0; tick(1);
    btn_clear = 1'b1;
    tick(5);
    chk("bounce_e5_count_reset", 4'(count_reset), 4'd0);
    tick(1);
    chk("bounce_e6_count_reset", 4'(count_reset), 4'd1);
    btn_clear = 1'b0;
    tick(8);
    chk("bounce_rel_state", 4'(state_dbg), 4'd0);
    tick(2);

    // Direction change 0 -> 1
    sw_down = 1'b1;
    tick(5);
    chk("dir_e5_count_down", 4'(count_down), 4'd0);
    chk("dir_e5_count_reset", 4'(count_reset), 4'd0);
    tick(1);
    chk("dir_e6_count_down", 4'(count_down), 4'd1);
    chk("dir_e6_count_reset", 4'(count_reset), 4'd1);
    tick(1);
    chk("dir_e7_ctr", ctr, 4'd15);
    chk("dir_e7_count_reset", 4'(count_reset), 4'd1);
    tick(1);
    chk("dir_e8_ctr", ctr, 4'd15);
    chk("dir_e8_count_reset", 4'(count_reset), 4'd0);
    tick(1);
    chk("dir_e9_ctr", ctr, 4'd14);
    tick(2);

    // Direction change accepted one cycle into CLEAR restarts the clear window
    btn_clear = 1'b1;
    tick(1);
    sw_down = 1'b0;
    tick(5);
    chk("tog_e6_state", 4'(state_dbg), 4'd1);
    chk("tog_e6_count_down", 4'(count_down), 4'd1);
    tick(1);
    chk("tog_e7_count_down", 4'(count_down), 4'd0);
    chk("tog_e7_state", 4'(state_dbg), 4'd1);
    tick(1);
    chk("tog_e8_state", 4'(state_dbg), 4'd1);
    chk("tog_e8_ctr", ctr, 4'd0);
    tick(1);
    chk("tog_e9_state", 4'(state_dbg), 4'd2);
    btn_clear = 1'b0;
    tick(8);
    chk("tog_rel_state", 4'(state_dbg), 4'd0);
    tick(2);

    // Async reset while a direction change is half debounced
    sw_down = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    chk("arst_count_reset", 4'(count_reset), 4'd1);
    chk("arst_count_down", 4'(count_down), 4'd0);
    chk("arst_state", 4'(state_dbg), 4'd1);
    tick(2);
    reset = 1'b1;
    tick(5);
    chk("arst_e5_count_down", 4'(count_down), 4'd0);
    tick(1);
    chk("arst_e6_count_down", 4'(count_down), 4'd1);
    chk("arst_e6_count_reset", 4'(count_reset), 4'd1);
    tick(5);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
